io_unit: RTL

IO_UNIT -- requirements
Module: io_unit

---
 rtl/mycpu_pkg.sv | 54 +++++
 rtl/io_fifo.sv | 58 +++++
 rtl/io_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/mycpu_pkg.sv
// Shared IO-unit definitions: register map, FIFO sizing and STATUS layout.
package mycpu_pkg;

  // IO register map, decoded from addr_in[1:0].
  typedef enum logic [1:0] {
    IO_DATA = 2'd0,  // TXDATA on write, RXDATA on read
    IO_STAT = 2'd1,  // STATUS on read, ERRCLR on write
    IO_SCR  = 2'd2,  // SCRATCH read/write
    IO_RSV  = 2'd3   // reserved: reads zero, writes ignored
  } io_addr_t;

  localparam int IO_FIFO_DEPTH = 4;
  localparam int IO_DATA_W     = 16;
  localparam int IO_CNT_W      = 3;

  // STATUS bit positions.
  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_FULL    = 2;
  localparam int ST_RX_EMPTY   = 3;
  localparam int ST_TX_OVF     = 4;
  localparam int ST_RX_UNF     = 5;
  localparam int ST_TX_CNT_LSB = 6;
  localparam int ST_RX_CNT_LSB = 9;

  // ERRCLR bit positions in the written data word.
  localparam int CLR_TX_OVF = 4;
  localparam int CLR_RX_UNF = 5;

  // Assemble the STATUS word; unused upper bits stay zero.
  function automatic logic [IO_DATA_W-1:0] pack_status(
    input logic                tx_full,
    input logic                tx_empty,
    input logic                rx_full,
    input logic                rx_empty,
    input logic                tx_ovf,
    input logic                rx_unf,
    input logic [IO_CNT_W-1:0] tx_cnt,
    input logic [IO_CNT_W-1:0] rx_cnt
  );
    logic [IO_DATA_W-1:0] s;
    s = '0;
    s[ST_TX_FULL]                    = tx_full;
    s[ST_TX_EMPTY]                   = tx_empty;
    s[ST_RX_FULL]                    = rx_full;
    s[ST_RX_EMPTY]                   = rx_empty;
    s[ST_TX_OVF]                     = tx_ovf;
    s[ST_RX_UNF]                     = rx_unf;
    s[ST_TX_CNT_LSB +: IO_CNT_W]     = tx_cnt;
    s[ST_RX_CNT_LSB +: IO_CNT_W]     = rx_cnt;
    return s;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// First-word-fall-through FIFO with occupancy count.
// A push while full is accepted only when a pop happens on the same edge,
// so a full FIFO can stream one-in/one-out. A pop while empty is ignored.
// rdata reads zero whenever the FIFO is empty.
module io_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage, pointers (wrapping at DEPTH) and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_unit.sv
// Memory-mapped IO unit: CPU-facing register file with a TX and an RX FIFO.
// Stream handshake (both tx_* and rx_*): a word transfers on the rising clock
// edge where valid and ready are both high; valid does not wait on ready.
module io_unit
  import mycpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iom_in,
  input  logic                 wen_in,
  input  logic                 rd_in,
  input  logic [15:0]          addr_in,
  input  logic [IO_DATA_W-1:0] data_in,
  output logic [IO_DATA_W-1:0] io_data_out,
  output logic [IO_DATA_W-1:0] tx_data_out,
  output logic                 tx_valid_out,
  input  logic                 tx_ready_in,
  input  logic [IO_DATA_W-1:0] rx_data_in,
  input  logic                 rx_valid_in,
  output logic                 rx_ready_out
);

  io_addr_t             addr;
  logic                 cpu_wr;
  logic                 cpu_rd;
  logic                 unused_addr_hi;

  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic [IO_CNT_W-1:0]  tx_count;
  logic                 rx_push, rx_rd, rx_full, rx_empty;
  logic [IO_CNT_W-1:0]  rx_count;
  logic [IO_DATA_W-1:0] rx_head;

  logic                 tx_ovf, rx_unf;
  logic                 tx_ovf_set, rx_unf_set, err_clr;
  logic [IO_DATA_W-1:0] scratch;
  logic [IO_DATA_W-1:0] status;

  assign addr           = io_addr_t'(addr_in[1:0]);
  assign unused_addr_hi = ^addr_in[15:2];
  assign cpu_wr         = iom_in & ~wen_in;
  assign cpu_rd         = iom_in & wen_in & rd_in;

  assign tx_push      = cpu_wr & (addr == IO_DATA);
  assign tx_valid_out = ~tx_empty;
  assign tx_pop       = tx_valid_out & tx_ready_in;

  assign rx_ready_out = ~rx_full;
  assign rx_push      = rx_valid_in & rx_ready_out;
  assign rx_rd        = cpu_rd & (addr == IO_DATA);

  // A write that finds TX full is lost unless the sink frees a slot that edge.
  assign tx_ovf_set = tx_push & tx_full & ~tx_pop;
  assign rx_unf_set = rx_rd & rx_empty;
  assign err_clr    = cpu_wr & (addr == IO_STAT);

  io_fifo #(.DEPTH(IO_FIFO_DEPTH), .WIDTH(IO_DATA_W), .CNT_W(IO_CNT_W)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (data_in),
    .rdata (tx_data_out),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  io_fifo #(.DEPTH(IO_FIFO_DEPTH), .WIDTH(IO_DATA_W), .CNT_W(IO_CNT_W)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (rx_rd),
    .wdata (rx_data_in),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign status = pack_status(tx_full, tx_empty, rx_full, rx_empty,
                              tx_ovf, rx_unf, tx_count, rx_count);

  // Sticky error flags (a new error beats a same-cycle clear) and SCRATCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ovf  <= 1'b0;
      rx_unf  <= 1'b0;
      scratch <= '0;
    end else begin
      tx_ovf <= tx_ovf_set | (tx_ovf & ~(err_clr & data_in[CLR_TX_OVF]));
      rx_unf <= rx_unf_set | (rx_unf & ~(err_clr & data_in[CLR_RX_UNF]));
      if (cpu_wr && (addr == IO_SCR)) scratch <= data_in;
    end
  end

  // CPU read mux; zero when no read is active or the target has nothing to return.
  always_comb begin
    io_data_out = '0;
    if (cpu_rd) begin
      case (addr)
        IO_DATA: io_data_out = rx_head;
        IO_STAT: io_data_out = status;
        IO_SCR:  io_data_out = scratch;
        default: io_data_out = '0;
      endcase
    end
  end

endmodule
